// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
// Holds the packer FSM encoding and the partial-word keep mask.
package fifo_pkg;

  typedef enum logic {
    COLLECT,
    FLUSH
  } packer_state_e;

  function automatic logic [31:0] keep_mask(input logic [31:0] c);
    return (32'd1 << c) - 32'd1;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Valid/ready holding register for the packed output word.
// A load is only issued while the slot is free or draining this cycle.
module stream_out_reg #(
  parameter int DW = 32,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [DW-1:0] ld_data,
  input  logic [KW-1:0] ld_keep,
  input  logic          ld_last,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [KW-1:0] m_keep,
  output logic          m_last,
  output logic          m_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
      m_valid <= 1'b0;
    end else if (ld) begin
      m_data  <= ld_data;
      m_keep  <= ld_keep;
      m_last  <= ld_last;
      m_valid <= 1'b1;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops narrow FIFO words and packs PACK_RATIO of them per output word.
// A flush closes a partial word with a keep mask and a last marker.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            fifo_rd_data,
  input  logic                             fifo_empty,
  output logic                             fifo_rd_en,
  input  logic                             flush,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
  output logic [PACK_RATIO-1:0]            m_keep,
  output logic                             m_last,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic                             flush_done,
  output logic                             busy
);

  localparam int CW = $clog2(PACK_RATIO);
  localparam int AW = (PACK_RATIO - 1) * DATA_WIDTH;
  localparam int OW = DATA_WIDTH * PACK_RATIO;
  localparam logic [CW-1:0] LAST = CW'(PACK_RATIO - 1);

  packer_state_e state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] acc;

  logic            out_free;
  logic            pop;
  logic            full_ld;
  logic            flush_ld;
  logic            flush_end;
  logic            ld;
  logic [OW-1:0]   ld_data;
  logic [PACK_RATIO-1:0] ld_keep;
  logic            ld_last;

  assign out_free  = !m_valid || m_ready;
  assign pop       = !rst && state == COLLECT && !fifo_empty
                     && (cnt != LAST || out_free);
  assign fifo_rd_en = pop;
  assign full_ld   = pop && cnt == LAST;
  assign flush_ld  = state == FLUSH && cnt != '0 && out_free;
  assign flush_end = state == FLUSH && (cnt == '0 || out_free);
  assign ld        = full_ld || flush_ld;
  assign busy      = state == FLUSH || cnt != '0 || m_valid;

  // acc is cleared whenever a word closes, so unused lanes read as zero
  always_comb begin
    ld_data = {fifo_rd_data, acc};
    ld_keep = '1;
    ld_last = 1'b0;
    if (flush_ld) begin
      ld_data = {{DATA_WIDTH{1'b0}}, acc};
      ld_keep = PACK_RATIO'(keep_mask(32'(cnt)));
      ld_last = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= COLLECT;
      cnt        <= '0;
      acc        <= '0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= flush_end;
      if (pop) begin
        if (cnt == LAST) begin
          cnt <= '0;
          acc <= '0;
        end else begin
          acc[cnt*DATA_WIDTH +: DATA_WIDTH] <= fifo_rd_data;
          cnt <= cnt + CW'(1);
        end
      end
      if (flush_ld) begin
        cnt <= '0;
        acc <= '0;
      end
      unique case (state)
        COLLECT: if (flush) state <= FLUSH;
        FLUSH:   if (flush_end) state <= COLLECT;
        default: state <= COLLECT;
      endcase
    end
  end

  stream_out_reg #(
    .DW(OW),
    .KW(PACK_RATIO)
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .ld      (ld),
    .ld_data (ld_data),
    .ld_keep (ld_keep),
    .ld_last (ld_last),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_last  (m_last),
    .m_valid (m_valid)
  );

endmodule
